bayer_linebuf_ctrl: RTL and testbench

//  Line-buffer sequencer for the Bayer2RGB path.

---
 rtl/bayer_pkg.sv | 16 +
 rtl/line_ram_rf.sv | 24 ++
 rtl/bayer_linebuf_ctrl.sv | 124 ++++++++++++
 tb/tb_bayer_linebuf_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/bayer_pkg.sv
// rtl/bayer_pkg.sv - shared types and Bayer phase constants for the Bayer2RGB line-buffer path
package bayer_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  // RGGB mosaic: phase = {row[0], col[0]}
  localparam logic [1:0] PH_R  = 2'b00;
  localparam logic [1:0] PH_GR = 2'b01;
  localparam logic [1:0] PH_GB = 2'b10;
  localparam logic [1:0] PH_B  = 2'b11;

  function automatic logic [1:0] bayer_phase(input logic row_odd, input logic col_odd);
    return {row_odd, col_odd};
  endfunction

endpackage

// File: rtl/line_ram_rf.sv
// rtl/line_ram_rf.sv - one-line simple dual-port RAM, registered read, read-first on collision
module line_ram_rf #(
  parameter int DW    = 8,
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          clk_r,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // Read register holds while rd_en is low so tap outputs hold across stream gaps.
  always_ff @(posedge clk_r) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/bayer_linebuf_ctrl.sv
// rtl/bayer_linebuf_ctrl.sv - raster sequencer driving two line RAMs as a cascaded delay line
module bayer_linebuf_ctrl
  import bayer_pkg::*;
#(
  parameter int DW    = 8,
  parameter int IMG_W = 128,
  parameter int IMG_H = 64,
  localparam int AW   = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic          clk_r,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_tap0,
  output logic [DW-1:0] out_tap1,
  output logic [DW-1:0] out_tap2,
  output logic [AW-1:0] out_col,
  output logic [RW-1:0] out_row,
  output logic [1:0]    out_phase,
  output logic          out_sof,
  output logic          out_eol,
  output logic          frame_done,
  output logic          busy
);

  localparam logic [AW-1:0] COL_LAST = AW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_t        state;
  logic [AW-1:0] col;
  logic [RW-1:0] row;
  logic [AW-1:0] cur_c;
  logic [RW-1:0] cur_r;
  logic          accept;
  logic          last_col;
  logic          last_row;
  logic          wr1_en;
  logic [AW-1:0] wr1_addr;
  logic [DW-1:0] ram0_rd;
  logic [DW-1:0] ram1_rd;

  // An in_sof pixel is always position (0,0), whether starting or resynchronising.
  always_comb begin
    accept   = in_valid & (in_sof | (state == RUN));
    cur_c    = in_sof ? '0 : col;
    cur_r    = in_sof ? '0 : row;
    last_col = (cur_c == COL_LAST);
    last_row = (cur_r == ROW_LAST);
  end

  always_ff @(posedge clk_r or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      wr1_en     <= 1'b0;
      wr1_addr   <= '0;
      out_valid  <= 1'b0;
      out_tap0   <= '0;
      out_col    <= '0;
      out_row    <= '0;
      out_phase  <= '0;
      out_sof    <= 1'b0;
      out_eol    <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      wr1_en     <= accept;
      out_valid  <= accept;
      out_sof    <= 1'b0;
      out_eol    <= 1'b0;
      frame_done <= 1'b0;
      if (accept) begin
        wr1_addr   <= cur_c;
        out_tap0   <= in_data;
        out_col    <= cur_c;
        out_row    <= cur_r;
        out_phase  <= bayer_phase(cur_r[0], cur_c[0]);
        out_sof    <= in_sof;
        out_eol    <= last_col;
        frame_done <= last_col & last_row;
        col        <= last_col ? '0 : cur_c + 1'b1;
        if (last_col) row <= last_row ? '0 : cur_r + 1'b1;
        else          row <= cur_r;
        if (last_col && last_row) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          state <= RUN;
          busy  <= 1'b1;
        end
      end
    end
  end

  // RAM0 holds line r-1; its read data cascades into RAM1 one cycle later to form line r-2.
  line_ram_rf #(.DW(DW), .DEPTH(IMG_W), .AW(AW)) u_ram0 (
    .clk_r   (clk_r),
    .wr_en   (accept),
    .wr_addr (cur_c),
    .wr_data (in_data),
    .rd_en   (accept),
    .rd_addr (cur_c),
    .rd_data (ram0_rd)
  );

  line_ram_rf #(.DW(DW), .DEPTH(IMG_W), .AW(AW)) u_ram1 (
    .clk_r   (clk_r),
    .wr_en   (wr1_en),
    .wr_addr (wr1_addr),
    .wr_data (ram0_rd),
    .rd_en   (accept),
    .rd_addr (cur_c),
    .rd_data (ram1_rd)
  );

  // Border masking also hides uninitialised or stale RAM contents after reset/resync.
  assign out_tap1 = (out_row == '0)      ? '0 : ram0_rd;
  assign out_tap2 = (out_row <= RW'(1))  ? '0 : ram1_rd;

endmodule

// File: tb/tb_bayer_linebuf_ctrl.sv
// tb/tb_bayer_linebuf_ctrl.sv - directed self-checking bench for bayer_linebuf_ctrl on a 4x4 frame
module tb_bayer_linebuf_ctrl;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  logic          clk_r = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic [DW-1:0] out_tap0, out_tap1, out_tap2;
  logic [1:0]    out_col;
  logic [1:0]    out_row;
  logic [1:0]    out_phase;
  logic          out_sof, out_eol, frame_done, busy;

  int total = 0;
  int bad = 0;

  bayer_linebuf_ctrl #(.DW(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk_r      (clk_r),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_tap0   (out_tap0),
    .out_tap1   (out_tap1),
    .out_tap2   (out_tap2),
    .out_col    (out_col),
    .out_row    (out_row),
    .out_phase  (out_phase),
    .out_sof    (out_sof),
    .out_eol    (out_eol),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk_r = ~clk_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pix(input int r, input int c);
    return 32'((r * 16 + c) & 8'hFF);
  endfunction

  task automatic step(input logic v, input logic s, input logic [DW-1:0] d);
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    @(posedge clk_r);
    #1;
  endtask

  task automatic run_px(input int r, input int c, input logic s);
    step(1'b1, s, DW'(pix(r, c)));
    chk($sformatf("valid@%0d,%0d", r, c), 32'(out_valid), 32'd1);
    chk($sformatf("tap0@%0d,%0d", r, c), 32'(out_tap0), pix(r, c));
    chk($sformatf("tap1@%0d,%0d", r, c), 32'(out_tap1), (r >= 1) ? pix(r - 1, c) : 32'd0);
    chk($sformatf("tap2@%0d,%0d", r, c), 32'(out_tap2), (r >= 2) ? pix(r - 2, c) : 32'd0);
    chk($sformatf("col@%0d,%0d", r, c), 32'(out_col), 32'(c));
    chk($sformatf("row@%0d,%0d", r, c), 32'(out_row), 32'(r));
    chk($sformatf("phase@%0d,%0d", r, c), 32'(out_phase), 32'(((r % 2) * 2) + (c % 2)));
    chk($sformatf("sof@%0d,%0d", r, c), 32'(out_sof), 32'(r == 0 && c == 0));
    chk($sformatf("eol@%0d,%0d", r, c), 32'(out_eol), 32'(c == W - 1));
    chk($sformatf("fdone@%0d,%0d", r, c), 32'(frame_done), 32'(r == H - 1 && c == W - 1));
    chk($sformatf("busy@%0d,%0d", r, c), 32'(busy), 32'(!(r == H - 1 && c == W - 1)));
    if (r == 2 && c == 3)
      chk("px23_taps", 32'({out_tap0, out_tap1, out_tap2}), 32'h00231303);
  endtask

  task automatic gap(input int r, input int c);
    step(1'b0, 1'b0, 8'hEE);
    chk($sformatf("gap_valid@%0d,%0d", r, c), 32'(out_valid), 32'd0);
    chk($sformatf("gap_fdone@%0d,%0d", r, c), 32'(frame_done), 32'd0);
    chk($sformatf("gap_tap0@%0d,%0d", r, c), 32'(out_tap0), pix(r, c));
    chk($sformatf("gap_col@%0d,%0d", r, c), 32'(out_col), 32'(c));
    chk($sformatf("gap_row@%0d,%0d", r, c), 32'(out_row), 32'(r));
  endtask

  task automatic frame(input bit gaps);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        run_px(r, c, r == 0 && c == 0);
        if (gaps) gap(r, c);
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_tap0"}, 32'(out_tap0), 32'd0);
    chk({tag, "_tap1"}, 32'(out_tap1), 32'd0);
    chk({tag, "_tap2"}, 32'(out_tap2), 32'd0);
    chk({tag, "_col"}, 32'(out_col), 32'd0);
    chk({tag, "_row"}, 32'(out_row), 32'd0);
    chk({tag, "_phase"}, 32'(out_phase), 32'd0);
    chk({tag, "_sof"}, 32'(out_sof), 32'd0);
    chk({tag, "_eol"}, 32'(out_eol), 32'd0);
    chk({tag, "_fdone"}, 32'(frame_done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // reset state
    #2 rst_n = 1'b0;
    #1 chk_zero("rst");
    @(posedge clk_r);
    @(posedge clk_r);
    #1 rst_n = 1'b1;

    // continuous frame, then frame-end behaviour
    frame(1'b0);
    step(1'b0, 1'b0, 8'h00);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_fdone", 32'(frame_done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 8'h55);
      chk($sformatf("idle_valid%0d", i), 32'(out_valid), 32'd0);
      chk($sformatf("idle_busy%0d", i), 32'(busy), 32'd0);
    end

    // gapped frame
    frame(1'b1);

    // resync at (2,1)
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < W; c++)
        run_px(r, c, r == 0 && c == 0);
    run_px(2, 0, 1'b0);
    run_px(0, 0, 1'b1);
    for (int i = 1; i < W * H; i++)
      run_px(i / W, i % W, 1'b0);

    // asynchronous reset at (1,2)
    for (int c = 0; c < W; c++) run_px(0, c, c == 0);
    run_px(1, 0, 1'b0);
    run_px(1, 1, 1'b0);
    rst_n = 1'b0;
    #2 chk_zero("midrst");
    @(posedge clk_r);
    #1 rst_n = 1'b1;
    frame(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
